// File: rtl/capture_sequencer_pkg.sv
// Shared state and source-select codes for the scope capture sequencer.
package capture_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HOLDOFF = 2'b10,
        ST_FROZEN  = 2'b11
    } seq_state_t;

    localparam logic [1:0] SRC_VOICE0 = 2'd0;
    localparam logic [1:0] SRC_VOICE1 = 2'd1;
    localparam logic [1:0] SRC_VOICE2 = 2'd2;
    localparam logic [1:0] SRC_MIX    = 2'd3;

endpackage

// File: rtl/capture_sequencer_sample_decimator.sv
// Forwards one of every decim+1 sample strobes, registering the sample
// and issuing a single-cycle strobe to the capture block.
module capture_sequencer_sample_decimator #(
    parameter int SW      = 16,
    parameter int DECIM_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               enable,
    input  logic               strobe_in,
    input  logic [SW-1:0]      sample_in,
    input  logic [DECIM_W-1:0] decim,
    output logic               strobe_out,
    output logic [SW-1:0]      sample_out
);

    logic [DECIM_W-1:0] dec_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt    <= '0;
            strobe_out <= 1'b0;
            sample_out <= '0;
        end else begin
            strobe_out <= 1'b0;
            if (load) begin
                dec_cnt <= '0;
            end else if (enable && strobe_in) begin
                // terminal count reached: forward this sample and rearm
                if (dec_cnt == '0) begin
                    sample_out <= sample_in;
                    strobe_out <= 1'b1;
                    dec_cnt    <= decim;
                end else begin
                    dec_cnt <= dec_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Voice select, timebase decimation, inter-frame holdoff and display freeze
// in front of the wave capture block; config is applied only in LOAD.
//
//   state   | meaning
//   LOAD    | latch src_sel/decim/holdoff, clear decimator (one cycle)
//   RUN     | forward decimated samples until frame end
//   HOLDOFF | skip active_hold input samples before next frame
//   FROZEN  | no forwarding while freeze is held
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int SW      = 16,
    parameter int DECIM_W = 4,
    parameter int HOLD_W  = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_ready_in,
    input  logic [SW-1:0]      voice0_in,
    input  logic [SW-1:0]      voice1_in,
    input  logic [SW-1:0]      voice2_in,
    input  logic [SW-1:0]      mix_in,
    input  logic [1:0]         src_sel,
    input  logic [DECIM_W-1:0] decim,
    input  logic [HOLD_W-1:0]  holdoff,
    input  logic               freeze,
    input  logic               cap_write_enable,
    output logic               cap_sample_ready,
    output logic [SW-1:0]      cap_sample,
    output logic [1:0]         seq_state,
    output logic [7:0]         frames_captured
);

    seq_state_t         state, state_next;
    logic [1:0]         active_sel;
    logic [DECIM_W-1:0] active_decim;
    logic [HOLD_W-1:0]  active_hold;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               we_prev;
    logic [SW-1:0]      sel_sample;
    logic               frame_end;
    logic               load_cfg, fwd_en, frame_inc, hold_start, hold_tick;

    assign frame_end = we_prev & ~cap_write_enable;
    assign seq_state = state;

    always_comb begin
        sel_sample = voice0_in;
        unique case (active_sel)
            SRC_VOICE0: sel_sample = voice0_in;
            SRC_VOICE1: sel_sample = voice1_in;
            SRC_VOICE2: sel_sample = voice2_in;
            SRC_MIX:    sel_sample = mix_in;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        fwd_en     = 1'b0;
        frame_inc  = 1'b0;
        hold_start = 1'b0;
        hold_tick  = 1'b0;
        unique case (state)
            ST_LOAD: begin
                load_cfg   = 1'b1;
                state_next = freeze ? ST_FROZEN : ST_RUN;
            end
            ST_RUN: begin
                // a strobe coinciding with the frame end is dropped
                if (frame_end) begin
                    frame_inc = 1'b1;
                    if (freeze) begin
                        state_next = ST_FROZEN;
                    end else if (active_hold == '0) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_HOLDOFF;
                        hold_start = 1'b1;
                    end
                end else if (freeze && !cap_write_enable) begin
                    state_next = ST_FROZEN;
                end else begin
                    fwd_en = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (freeze) begin
                    state_next = ST_FROZEN;
                end else if (sample_ready_in) begin
                    hold_tick = 1'b1;
                    if (hold_cnt <= HOLD_W'(1)) state_next = ST_LOAD;
                end
            end
            ST_FROZEN: begin
                if (!freeze) state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_sel      <= '0;
            active_decim    <= '0;
            active_hold     <= '0;
            hold_cnt        <= '0;
            we_prev         <= 1'b0;
            frames_captured <= '0;
        end else begin
            we_prev <= cap_write_enable;
            if (load_cfg) begin
                active_sel   <= src_sel;
                active_decim <= decim;
                active_hold  <= holdoff;
            end
            if (frame_inc) frames_captured <= frames_captured + 8'd1;
            if (hold_start) begin
                hold_cnt <= active_hold;
            end else if (hold_tick && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    capture_sequencer_sample_decimator #(
        .SW      (SW),
        .DECIM_W (DECIM_W)
    ) u_decimator (
        .clk        (clk),
        .reset      (reset),
        .load       (load_cfg),
        .enable     (fwd_en),
        .strobe_in  (sample_ready_in),
        .sample_in  (sel_sample),
        .decim      (active_decim),
        .strobe_out (cap_sample_ready),
        .sample_out (cap_sample)
    );

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer.
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ready_in;
    logic [15:0] voice0_in, voice1_in, voice2_in, mix_in;
    logic [1:0]  src_sel;
    logic [3:0]  decim;
    logic [11:0] holdoff;
    logic        freeze;
    logic        cap_write_enable;
    logic        cap_sample_ready;
    logic [15:0] cap_sample;
    logic [1:0]  seq_state;
    logic [7:0]  frames_captured;

    int tests_run    = 0;
    int tests_failed = 0;

    capture_sequencer #(.SW(16), .DECIM_W(4), .HOLD_W(12)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_ready_in  (sample_ready_in),
        .voice0_in        (voice0_in),
        .voice1_in        (voice1_in),
        .voice2_in        (voice2_in),
        .mix_in           (mix_in),
        .src_sel          (src_sel),
        .decim            (decim),
        .holdoff          (holdoff),
        .freeze           (freeze),
        .cap_write_enable (cap_write_enable),
        .cap_sample_ready (cap_sample_ready),
        .cap_sample       (cap_sample),
        .seq_state        (seq_state),
        .frames_captured  (frames_captured)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_strobe(output logic pulse, output logic [1:0] st, output logic [15:0] smp);
        sample_ready_in = 1'b1;
        tick();
        pulse = cap_sample_ready;
        st    = seq_state;
        smp   = cap_sample;
        sample_ready_in = 1'b0;
        tick();
    endtask

    // leaves the DUT in RUN with the given config latched
    task automatic apply_reset(input logic [1:0] sel, input logic [3:0] dec, input logic [11:0] hold);
        src_sel = sel; decim = dec; holdoff = hold;
        freeze = 1'b0; cap_write_enable = 1'b0; sample_ready_in = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic frame_pulse();
        cap_write_enable = 1'b1;
        tick();
        cap_write_enable = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        p;
        logic [1:0]  st;
        logic [15:0] smp;
        int          npulse;

        reset = 1'b1; sample_ready_in = 1'b0; freeze = 1'b0; cap_write_enable = 1'b0;
        voice0_in = 16'h1111; voice1_in = 16'h5555; voice2_in = 16'h2222; mix_in = 16'h0000;
        src_sel = 2'd3; decim = 4'd0; holdoff = 12'd0;
        tick();
        check("rst_state",  seq_state, 2'b00);
        check("rst_ready",  cap_sample_ready, 1'b0);
        check("rst_sample", cap_sample, 16'h0000);
        check("rst_frames", frames_captured, 8'd0);
        reset = 1'b0;
        tick();
        check("post_rst_run", seq_state, 2'b01);

        // mix source, no decimation
        mix_in = 16'h8000;
        sample_ready_in = 1'b1;
        #1 check("lat_no_early", cap_sample_ready, 1'b0);
        tick();
        check("s1_pulse", cap_sample_ready, 1'b1);
        check("s1_data",  cap_sample, 16'h8000);
        sample_ready_in = 1'b0;
        mix_in = 16'h0100;
        tick();
        check("s1_one_cycle", cap_sample_ready, 1'b0);
        check("s1_hold",      cap_sample, 16'h8000);
        send_strobe(p, st, smp);
        check("s2_pulse", p, 1'b1);
        check("s2_data",  smp, 16'h0100);

        // decim=3 latched at the next frame boundary
        decim = 4'd3;
        frame_pulse();
        check("dec_frames", frames_captured, 8'd1);
        check("dec_load",   seq_state, 2'b00);
        tick();
        check("dec_run", seq_state, 2'b01);
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            send_strobe(p, st, smp);
            check($sformatf("dec_s%0d", i + 1), p, (i % 4 == 0) ? 1'b1 : 1'b0);
            if (p) npulse++;
        end
        check("dec_count", npulse, 3);

        // holdoff of 10 input samples
        apply_reset(2'd3, 4'd0, 12'd10);
        frame_pulse();
        check("ho_frames", frames_captured, 8'd1);
        check("ho_state",  seq_state, 2'b10);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            send_strobe(p, st, smp);
            if (p) npulse++;
            if (i == 8) check("ho_s9_state", st, 2'b10);
            if (i == 9) check("ho_s10_load", st, 2'b00);
        end
        check("ho_no_pulses", npulse, 0);
        check("ho_back_run", seq_state, 2'b01);
        mix_in = 16'h1234;
        send_strobe(p, st, smp);
        check("ho_s11_pulse", p, 1'b1);
        check("ho_s11_data",  smp, 16'h1234);

        // freeze during a frame waits for frame end
        apply_reset(2'd3, 4'd0, 12'd0);
        cap_write_enable = 1'b1;
        tick();
        freeze = 1'b1;
        mix_in = 16'h4321;
        send_strobe(p, st, smp);
        check("frz_fwd_pulse", p, 1'b1);
        check("frz_fwd_state", st, 2'b01);
        cap_write_enable = 1'b0;
        tick();
        check("frz_frozen", seq_state, 2'b11);
        check("frz_frames", frames_captured, 8'd1);
        send_strobe(p, st, smp);
        check("frz_no_pulse", p, 1'b0);
        freeze = 1'b0;
        tick();
        check("frz_rel_load", seq_state, 2'b00);
        tick();
        check("frz_rel_run", seq_state, 2'b01);
        // freeze with no frame in progress is immediate
        freeze = 1'b1;
        tick();
        check("frz_idle_immediate", seq_state, 2'b11);
        send_strobe(p, st, smp);
        check("frz_idle_no_pulse", p, 1'b0);
        freeze = 1'b0;
        tick();
        tick();
        check("frz_idle_rel_run", seq_state, 2'b01);

        // src_sel change mid-frame
        apply_reset(2'd0, 4'd0, 12'd0);
        cap_write_enable = 1'b1;
        tick();
        src_sel = 2'd2;
        send_strobe(p, st, smp);
        check("sel_old_pulse", p, 1'b1);
        check("sel_old_data",  smp, 16'h1111);
        cap_write_enable = 1'b0;
        tick();
        tick();
        send_strobe(p, st, smp);
        check("sel_new_pulse", p, 1'b1);
        check("sel_new_data",  smp, 16'h2222);

        // strobe coinciding with frame end is dropped
        apply_reset(2'd3, 4'd0, 12'd0);
        cap_write_enable = 1'b1;
        tick();
        cap_write_enable = 1'b0;
        sample_ready_in  = 1'b1;
        tick();
        sample_ready_in = 1'b0;
        check("coin_no_pulse", cap_sample_ready, 1'b0);
        check("coin_load",     seq_state, 2'b00);
        check("coin_frames",   frames_captured, 8'd1);

        // frame counter wrap
        apply_reset(2'd3, 4'd0, 12'd0);
        for (int i = 0; i < 256; i++) begin
            frame_pulse();
            tick();
            if (i == 254) check("wrap_255", frames_captured, 8'd255);
        end
        check("wrap_0",   frames_captured, 8'd0);
        check("wrap_run", seq_state, 2'b01);

        // asynchronous reset mid-RUN with a pulse in flight
        apply_reset(2'd3, 4'd0, 12'd0);
        mix_in = 16'h7777;
        sample_ready_in = 1'b1;
        tick();
        check("arst_pulse_pre", cap_sample_ready, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_ready",  cap_sample_ready, 1'b0);
        check("arst_state",  seq_state, 2'b00);
        check("arst_sample", cap_sample, 16'h0000);
        sample_ready_in = 1'b0;
        reset = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sits between the codec/note-player sample stream and the wave capture block.
- Selects which voice feeds the scope and decimates the sample strobe (timebase).
- Enforces a holdoff between captured frames and freezes the display on request.
- Watches the capture block's write_enable to detect frame boundaries; all config changes take effect only at frame boundaries.

Parameters:
- SW, 16, sample width (two's complement)
- DECIM_W, 4, width of decimation ratio input
- HOLD_W, 12, width of holdoff sample count

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_ready_in  in  1  one-cycle strobe, new samples valid on voice inputs
- voice0_in  in  SW  note player 0 sample
- voice1_in  in  SW  note player 1 sample
- voice2_in  in  SW  note player 2 sample
- mix_in  in  SW  summed output sample
- src_sel  in  2  0..2 = voice0..2, 3 = mix
- decim  in  DECIM_W  forward 1 of every decim+1 samples
- holdoff  in  HOLD_W  input samples to skip after each frame
- freeze  in  1  level; hold the current display
- cap_write_enable  in  1  write_enable from the capture block
- cap_sample_ready  out  1  strobe to capture block new_sample_ready
- cap_sample  out  SW  sample to capture block new_sample_in
- seq_state  out  2  current state (debug/LED)
- frames_captured  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset is asynchronous and active-high; all state is held in flops cleared by it.
- Reset values: state=LOAD, cap_sample_ready=0, cap_sample=0, frames_captured=0, active_sel=0, active_decim=0, hold_cnt=0, dec_cnt=0, we_prev=0.
- LOAD (one cycle):
  - latch src_sel->active_sel, decim->active_decim, holdoff->active_hold; dec_cnt=0.
  - next state is FROZEN if freeze=1, else RUN.
- RUN, on each sample_ready_in:
  - if dec_cnt==0: register the selected sample into cap_sample, pulse cap_sample_ready exactly one cycle, set dec_cnt=active_decim.
  - else dec_cnt-1, no pulse.
  - Latency: cap_sample_ready rises the cycle after sample_ready_in.
- Frame end: falling edge of cap_write_enable (we_prev=1, now 0), detected in RUN:
  - frames_captured+1.
  - next state is FROZEN if freeze=1; else LOAD if active_hold==0; else HOLDOFF with hold_cnt=active_hold.
  - If a sample_ready_in arrives in the same cycle, it is dropped (no pulse).
- freeze in RUN:
  - if cap_write_enable=0 (no frame in progress): go to FROZEN immediately, no further pulses.
  - if cap_write_enable=1: keep forwarding until frame end, then go to FROZEN (display buffer stays coherent).
- HOLDOFF:
  - no pulses; each sample_ready_in decrements hold_cnt; when it reaches 0, go to LOAD.
  - freeze=1 goes to FROZEN.
- FROZEN: no pulses; freeze=0 goes to LOAD.
- src_sel, decim and holdoff changes mid-frame have no effect until the next LOAD.
- cap_sample holds its last value between pulses.
- Reset mid-frame: outputs clear asynchronously; the pulse in flight is lost.
- frames_captured wraps modulo 256.
- seq_state encoding: LOAD=2'b00, RUN=2'b01, HOLDOFF=2'b10, FROZEN=2'b11.

Decomposition:
- Shared constants header: the four state codes and the src_sel codes (VOICE0..2, MIX).
- One natural sub-module, sample_decimator:
  - contains dec_cnt, load, strobe-in/strobe-out logic and the output data register.
  - instantiated once; the FSM, holdoff counter and frame counter stay in the top level.

Test Plan:
- Reset then src_sel=3, decim=0, holdoff=0, samples 0x8000,0x0100 strobed -> pulses on both, cap_sample=0x8000 then 0x0100, each one cycle after its strobe.
- decim=3, 12 strobes -> exactly 3 pulses, on strobes 1, 5, 9.
- holdoff=10: cap_write_enable held 1 then dropped -> frames_captured=1, seq_state=2'b10, zero pulses for the next 10 strobes, LOAD on strobe 10, forwarding resumes with strobe 11.
- freeze=1 while cap_write_enable=1 -> forwarding continues until the falling edge, then FROZEN with no pulses. Release freeze -> LOAD (one cycle) then RUN.
- src_sel changed 0->2 mid-frame -> cap_sample keeps tracking voice0 until the frame end plus LOAD, then voice2.
- Falling edge of cap_write_enable coincident with sample_ready_in -> no pulse in that cycle. Also: 256 frames -> frames_captured wraps to 0. Also: assert reset mid-RUN -> cap_sample_ready=0 and seq_state=2'b00 without waiting for a clk edge.
